serial_addsub: RTL and testbench

- Parametrised bit-serial adder/subtractor. It is the sequential successor to the team's single-bit half-adder cells.
- It processes one bit per clock through a single full-adder slice and a carry flip-flop.
- It takes two WIDTH-bit operands with a start/done handshake and returns sum, carry-out and signed overflow.
- It is used where area matters more than latency, for example in counter and accumulator datapaths.

---
 rtl/serial_addsub_if.sv | 26 ++
 rtl/serial_addsub.sv | 84 ++++++++
 tb/tb_serial_addsub.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
`timescale 1ns/1ps
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop,
// LSB first, result valid for one cycle in DONE.
`timescale 1ns/1ps
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic s;
  logic cn;

  always_comb begin
    s  = ra[0] ^ rb[0] ^ c;
    cn = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back issue
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            ra    <= bus.a;
            rb    <= bus.sub ? ~bus.b : bus.b;
            c     <= bus.sub | bus.cin;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          res <= {s, res[WIDTH-1:1]};
          c   <= cn;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // c is the carry into the MSB here, cn the carry out of it
            sum_q  <= {s, res[WIDTH-1:1]};
            cout_q <= cn;
            ovf_q  <= c ^ cn;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomised checks of serial_addsub at WIDTH 8, 2 and 33.
`timescale 1ns/1ps
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  i8 ();
  serial_addsub_if #(.WIDTH(2))  i2 ();
  serial_addsub_if #(.WIDTH(33)) i33 ();

  serial_addsub #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
  serial_addsub #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(i2));
  serial_addsub #(.WIDTH(33)) u33 (.clk(clk), .rst(rst), .bus(i33));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 operation from the current cycle and wait for done.
  task automatic run_op8(input logic sb, input logic [7:0] va, input logic [7:0] vb,
                         input logic ci, output int lat, output int bc);
    i8.start = 1'b1; i8.sub = sb; i8.a = va; i8.b = vb; i8.cin = ci;
    tick();
    bc = int'(i8.busy);
    i8.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (i8.done) begin
        lat = k;
        break;
      end
      bc += int'(i8.busy);
    end
  endtask

  function automatic logic [65:0] model(input int w, input logic sb, input logic [63:0] va,
                                        input logic [63:0] vb, input logic ci);
    logic [63:0] mask, aa, bb, ss;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = va & mask;
    bb   = (sb ? ~vb : vb) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, (sb | ci)};
    ss   = full[63:0] & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (ss[w-1] != aa[w-1]);
    return {ov, co, ss};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    i8.start = 1'b1; i8.sub = 1'b0; i8.a = 8'h11; i8.b = 8'h22; i8.cin = 1'b0;
    i2.start = 1'b0; i2.sub = 1'b0; i2.a = '0; i2.b = '0; i2.cin = 1'b0;
    i33.start = 1'b0; i33.sub = 1'b0; i33.a = '0; i33.b = '0; i33.cin = 1'b0;
    tick();
    tick();
    checks++;
    if ({i8.busy, i8.done, i8.sum, i8.cout, i8.ovf} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               i8.busy, i8.done, i8.sum, i8.cout, i8.ovf);
    end
    rst = 1'b0;
    i8.start = 1'b0;
    tick();
    checks++;
    if (i8.busy !== 1'b0 || i8.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", i8.busy, i8.done);
    end
  endtask

  task automatic test_add();
    logic [7:0] va[4]  = '{8'h3C, 8'hFF, 8'h7F, 8'h00};
    logic [7:0] vb[4]  = '{8'h0F, 8'h01, 8'h01, 8'h00};
    logic       vc[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [9:0] exp[4] = '{{2'b00, 8'h4B}, {2'b01, 8'h00}, {2'b10, 8'h80}, {2'b00, 8'h01}};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op8(1'b0, va[i], vb[i], vc[i], lat, bc);
      checks++;
      if ({i8.ovf, i8.cout, i8.sum} !== exp[i]) begin
        fails++;
        $display("FAIL add_%0d: ovf/cout/sum=%b/%b/%h, required %b/%b/%h", i,
                 i8.ovf, i8.cout, i8.sum, exp[i][9], exp[i][8], exp[i][7:0]);
      end
      checks++;
      if (lat != 8 || bc != 8) begin
        fails++;
        $display("FAIL add_timing_%0d: done after %0d edges busy %0d cycles, required 8 and 8",
                 i, lat, bc);
      end
      tick();
    end
  endtask

  task automatic test_sub();
    logic [7:0] va[2]  = '{8'h05, 8'h80};
    logic [7:0] vb[2]  = '{8'h07, 8'h01};
    logic [9:0] exp[2] = '{{2'b00, 8'hFE}, {2'b11, 8'h7F}};
    int lat, bc;
    for (int i = 0; i < 2; i++) begin
      run_op8(1'b1, va[i], vb[i], 1'b1, lat, bc);
      checks++;
      if ({i8.ovf, i8.cout, i8.sum} !== exp[i] || lat != 8) begin
        fails++;
        $display("FAIL sub_%0d: ovf/cout/sum=%b/%b/%h lat=%0d, required %b/%b/%h lat=8", i,
                 i8.ovf, i8.cout, i8.sum, lat, exp[i][9], exp[i][8], exp[i][7:0]);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0, first = -1;
    logic [7:0] got = '0;
    i8.start = 1'b1; i8.sub = 1'b0; i8.a = 8'h12; i8.b = 8'h34; i8.cin = 1'b0;
    tick();
    for (int k = 1; k <= 20; k++) begin
      i8.start = (k == 3 || k == 5);
      i8.sub = 1'b1; i8.a = 8'hFF; i8.b = 8'hFF; i8.cin = 1'b1;
      tick();
      if (i8.done) begin
        ndone++;
        if (first < 0) begin
          first = k;
          got = i8.sum;
        end
      end
    end
    checks++;
    if (ndone != 1 || first != 8 || got !== 8'h46) begin
      fails++;
      $display("FAIL ignore_start: dones=%0d at %0d sum=%h, required 1 at 8 sum=46",
               ndone, first, got);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, k2 = -1;
    run_op8(1'b0, 8'h10, 8'h20, 1'b0, lat, bc);
    checks++;
    if (i8.sum !== 8'h30 || lat != 8) begin
      fails++;
      $display("FAIL b2b_first: sum=%h lat=%0d, required 30 lat=8", i8.sum, lat);
    end
    i8.start = 1'b1; i8.sub = 1'b1; i8.a = 8'h50; i8.b = 8'h30; i8.cin = 1'b0;
    tick();
    i8.start = 1'b0;
    checks++;
    if (i8.busy !== 1'b1 || i8.sum !== 8'h30) begin
      fails++;
      $display("FAIL b2b_restart: busy=%b sum=%h, required 1 and held 30", i8.busy, i8.sum);
    end
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (i8.done) begin
        k2 = k;
        break;
      end
    end
    checks++;
    if (k2 != 9 || {i8.ovf, i8.cout, i8.sum} !== {2'b01, 8'h20}) begin
      fails++;
      $display("FAIL b2b_second: done %0d cycles after first, ovf/cout/sum=%b/%b/%h, required 9 0/1/20",
               k2, i8.ovf, i8.cout, i8.sum);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int ndone = 0, lat, bc;
    i8.start = 1'b1; i8.sub = 1'b0; i8.a = 8'h3C; i8.b = 8'h0F; i8.cin = 1'b0;
    tick();
    i8.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({i8.busy, i8.done, i8.sum, i8.cout, i8.ovf} !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               i8.busy, i8.done, i8.sum, i8.cout, i8.ovf);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      ndone += int'(i8.done);
    end
    checks++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL reset_no_done: %0d done pulses, required 0", ndone);
    end
    run_op8(1'b0, 8'h22, 8'h11, 1'b0, lat, bc);
    checks++;
    if (i8.sum !== 8'h33 || lat != 8) begin
      fails++;
      $display("FAIL reset_recover: sum=%h lat=%0d, required 33 lat=8", i8.sum, lat);
    end
    tick();
  endtask

  task automatic test_random();
    int          w[3] = '{8, 2, 33};
    logic [65:0] exp[3], prev[3], got[3];
    logic        dn[3], seen[3];
    logic [63:0] va, vb;
    logic        sb, ci;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) prev[j] = '0;
    for (int it = 0; it < 30; it++) begin
      va = {$urandom, $urandom};
      vb = {$urandom, $urandom};
      sb = 1'($urandom);
      ci = 1'($urandom);
      if (it == 0) begin
        va = '1; vb = 64'd1; sb = 1'b0; ci = 1'b1;
      end
      for (int j = 0; j < 3; j++) begin
        exp[j]  = model(w[j], sb, va, vb, ci);
        seen[j] = 1'b0;
      end
      i8.a = va[7:0];   i8.b = vb[7:0];   i8.sub = sb;  i8.cin = ci;  i8.start = 1'b1;
      i2.a = va[1:0];   i2.b = vb[1:0];   i2.sub = sb;  i2.cin = ci;  i2.start = 1'b1;
      i33.a = va[32:0]; i33.b = vb[32:0]; i33.sub = sb; i33.cin = ci; i33.start = 1'b1;
      tick();
      i8.start = 1'b0; i2.start = 1'b0; i33.start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        got[0] = {i8.ovf, i8.cout, 56'd0, i8.sum};
        got[1] = {i2.ovf, i2.cout, 62'd0, i2.sum};
        got[2] = {i33.ovf, i33.cout, 31'd0, i33.sum};
        dn[0] = i8.done; dn[1] = i2.done; dn[2] = i33.done;
        for (int j = 0; j < 3; j++) begin
          checks++;
          if (dn[j]) begin
            if (got[j] !== exp[j] || seen[j] || k != w[j]) begin
              fails++;
              $display("FAIL rand_w%0d_it%0d: got %h at %0d, required %h at %0d",
                       w[j], it, got[j], k, exp[j], w[j]);
            end
            seen[j] = 1'b1;
            prev[j] = exp[j];
          end else if (got[j] !== prev[j]) begin
            fails++;
            $display("FAIL stable_w%0d_it%0d: outputs %h changed from %h without done",
                     w[j], it, got[j], prev[j]);
          end
        end
      end
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (!seen[j]) begin
          fails++;
          $display("FAIL rand_timeout_w%0d_it%0d: no done within 40 cycles", w[j], it);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
